// File: rtl/bird_motion_fsm.sv
// bird_motion_fsm
// Per-frame bird sequencer: DRAW -> ERASE -> UPD_POS -> UPD_VY, preceded by a
// one-cycle mode state (START / RISE / FALL), with S_STOP as the game-over hold.
// Integrates vertical position and velocity with flap impulse, gravity,
// terminal velocity and ceiling/ground clamping.
//
// Build option: define BIRD_FLAP_EDGE_EN to qualify press_key on its 0->1 edge
// only. Without it press_key qualifies on level, so a held key re-flaps every
// frame and also restarts from S_STOP.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  S_START   | idle mode, bird parked at Y_START until the first flap
//  S_RISE    | mode marker: bird moving up (vy < 0)
//  S_FALL    | mode marker: bird level or moving down (vy >= 0)
//  S_STOP    | game over, position frozen until a qualifying press
//  S_DRAW    | draw_en held for DRAW_CYCLES cycles
//  S_ERASE   | single-cycle erase strobe
//  S_UPD_POS | bird_y += vy with ceiling/ground clamp
//  S_UPD_VY  | flap impulse or gravity, choose next mode

module bird_motion_fsm #(
    parameter int Y_W         = 7,
    parameter int VY_W        = 5,
    parameter int DRAW_CYCLES = 128,
    parameter int Y_START     = 60,
    parameter int Y_TOP       = 0,
    parameter int Y_BOTTOM    = 112,
    parameter int FLAP_VY     = -4,
    parameter int GRAVITY     = 1,
    parameter int VY_MAX      = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   press_key,
    input  logic                   touched,
    output logic [3:0]             state,
    output logic [Y_W-1:0]         bird_y,
    output logic signed [VY_W-1:0] vy,
    output logic                   draw_en,
    output logic                   erase_en,
    output logic                   game_over
);

    typedef enum logic [3:0] {
        S_START   = 4'd0,
        S_RISE    = 4'd1,
        S_FALL    = 4'd2,
        S_STOP    = 4'd3,
        S_DRAW    = 4'd4,
        S_ERASE   = 4'd5,
        S_UPD_POS = 4'd6,
        S_UPD_VY  = 4'd7
    } state_t;

    localparam int CNT_W = (DRAW_CYCLES > 1) ? $clog2(DRAW_CYCLES) : 1;
    localparam int S_W   = Y_W + 2;
    localparam int V1_W  = VY_W + 1;

    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DRAW_CYCLES - 1);
    localparam logic signed [S_W-1:0]  Y_TOP_S  = S_W'(Y_TOP);
    localparam logic signed [S_W-1:0]  Y_BOT_S  = S_W'(Y_BOTTOM);
    localparam logic signed [V1_W-1:0] GRAV_S   = V1_W'(GRAVITY);
    localparam logic signed [V1_W-1:0] VMAX_S   = V1_W'(VY_MAX);

    state_t                 state_q, state_d;
    state_t                 mode_q, mode_d;
    logic [Y_W-1:0]         bird_y_q, bird_y_d;
    logic signed [VY_W-1:0] vy_q, vy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flap_q, flap_d;
    logic                   hit_q, hit_d;
    logic                   press_qual;

    logic signed [S_W-1:0]  sum;
    logic signed [V1_W-1:0] vy_inc;
    logic signed [VY_W-1:0] vy_sat;

`ifdef BIRD_FLAP_EDGE_EN
    logic press_prev_q;

    // One-cycle copy of the key so only a rising edge counts as a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) press_prev_q <= 1'b0;
        else       press_prev_q <= press_key;
    end

    assign press_qual = press_key & ~press_prev_q;
`else
    assign press_qual = press_key;
`endif

    // Position sum is widened by two bits so both overshoot directions stay visible
    assign sum    = $signed({2'b00, bird_y_q}) + $signed({{(S_W-VY_W){vy_q[VY_W-1]}}, vy_q});
    // Gravity step computed one bit wider so it saturates instead of wrapping
    assign vy_inc = $signed({vy_q[VY_W-1], vy_q}) + GRAV_S;
    assign vy_sat = (vy_inc > VMAX_S) ? VY_W'(VY_MAX) : vy_inc[VY_W-1:0];

    // State, mode, kinematics, draw counter and latch registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_START;
            mode_q   <= S_START;
            bird_y_q <= Y_W'(Y_START);
            vy_q     <= '0;
            cnt_q    <= '0;
            flap_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            bird_y_q <= bird_y_d;
            vy_q     <= vy_d;
            cnt_q    <= cnt_d;
            flap_q   <= flap_d;
            hit_q    <= hit_d;
        end
    end

    // Next-state, datapath update and latch set/clear
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        bird_y_d = bird_y_q;
        vy_d     = vy_q;
        cnt_d    = cnt_q;
        flap_d   = flap_q | press_qual;
        hit_d    = hit_q | (touched && (state_q != S_START) && (state_q != S_STOP));

        unique case (state_q)
            S_START, S_RISE, S_FALL: begin
                mode_d  = state_q;
                state_d = S_DRAW;
            end
            S_DRAW: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ERASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERASE: begin
                state_d = S_UPD_POS;
            end
            S_UPD_POS: begin
                if (mode_q != S_START) begin
                    if (sum < Y_TOP_S) begin
                        bird_y_d = Y_W'(Y_TOP);
                        vy_d     = '0;
                    end else if (sum >= Y_BOT_S) begin
                        bird_y_d = Y_W'(Y_BOTTOM);
                        hit_d    = 1'b1;
                    end else begin
                        bird_y_d = sum[Y_W-1:0];
                    end
                end
                state_d = S_UPD_VY;
            end
            S_UPD_VY: begin
                if (flap_q)                 vy_d = VY_W'(FLAP_VY);
                else if (mode_q != S_START) vy_d = vy_sat;

                if (hit_q)                                state_d = S_STOP;
                else if ((mode_q == S_START) && !flap_q) state_d = S_START;
                else if (vy_d[VY_W-1])                    state_d = S_RISE;
                else                                      state_d = S_FALL;

                // A press landing on the clear cycle still registers
                flap_d = press_qual;
            end
            S_STOP: begin
                if (press_qual) begin
                    bird_y_d = Y_W'(Y_START);
                    vy_d     = '0;
                    flap_d   = 1'b0;
                    hit_d    = 1'b0;
                    state_d  = S_START;
                end
            end
            default: begin
                state_d = S_START;
            end
        endcase
    end

    assign state     = state_q;
    assign bird_y    = bird_y_q;
    assign vy        = vy_q;
    assign draw_en   = (state_q == S_DRAW);
    assign erase_en  = (state_q == S_ERASE);
    assign game_over = (state_q == S_STOP);

endmodule

// File: tb/tb_bird_motion_fsm.sv
// Directed bench for bird_motion_fsm: idle frames, flap trajectory to ground,
// restart, collision, ceiling clamp (second instance with Y_START=2),
// held key behaviour and asynchronous reset.

module tb_bird_motion_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, press_key, touched;
    logic [3:0]        state;
    logic [6:0]        bird_y;
    logic signed [4:0] vy;
    logic              draw_en, erase_en, game_over;

    logic              rst_c, press_c, touched_c;
    logic [3:0]        state_c;
    logic [6:0]        bird_y_c;
    logic signed [4:0] vy_c;
    logic              draw_en_c, erase_en_c, game_over_c;

    int checks = 0;
    int errors = 0;

    bird_motion_fsm u_dut (
        .clk       (clk),
        .reset     (reset),
        .press_key (press_key),
        .touched   (touched),
        .state     (state),
        .bird_y    (bird_y),
        .vy        (vy),
        .draw_en   (draw_en),
        .erase_en  (erase_en),
        .game_over (game_over)
    );

    bird_motion_fsm #(.Y_START(2)) u_ceil (
        .clk       (clk),
        .reset     (rst_c),
        .press_key (press_c),
        .touched   (touched_c),
        .state     (state_c),
        .bird_y    (bird_y_c),
        .vy        (vy_c),
        .draw_en   (draw_en_c),
        .erase_en  (erase_en_c),
        .game_over (game_over_c)
    );

    // Advance to the negedge just after the main DUT's S_UPD_VY cycle
    task automatic frame_end();
        int n = 0;
        while (state !== 4'd7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (state !== 4'd7) begin
            checks++; errors++;
            $display("FAIL frame_timeout state=%0d", state);
        end
        @(negedge clk);
    endtask

    task automatic wait_main_state(input logic [3:0] s);
        int n = 0;
        while (state !== s && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (state !== s) begin
            checks++; errors++;
            $display("FAIL wait_state got=%0d exp=%0d", state, s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; press_key = 1'b0; touched = 1'b0;
        rst_c = 1'b1; press_c = 1'b0; touched_c = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 4'd0 || bird_y !== 7'd60 || vy !== 5'sd0) begin
            errors++;
            $display("FAIL reset_vals got st=%0d y=%0d vy=%0d exp st=0 y=60 vy=0", state, bird_y, vy);
        end
        checks++;
        if ({draw_en, erase_en, game_over} !== 3'b000) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=000", {draw_en, erase_en, game_over});
        end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int f = 0; f < 3; f++) begin
            int bad = 0;
            int dcnt = 0;
            for (int i = 0; i < 132; i++) begin
                int e;
                e = (i == 0) ? 0 : (i <= 128) ? 4 : (i == 129) ? 5 : (i == 130) ? 6 : 7;
                if (state !== 4'(e)) bad++;
                if (erase_en !== (i == 129)) bad++;
                if (draw_en === 1'b1) dcnt++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL idle_seq frame=%0d bad_cycles=%0d exp=0", f, bad);
            end
            checks++;
            if (dcnt != 128) begin
                errors++;
                $display("FAIL idle_draw_len frame=%0d got=%0d exp=128", f, dcnt);
            end
        end
        checks++;
        if (state !== 4'd0 || bird_y !== 7'd60 || vy !== 5'sd0) begin
            errors++;
            $display("FAIL idle_end got st=%0d y=%0d vy=%0d exp st=0 y=60 vy=0", state, bird_y, vy);
        end
    endtask

    task automatic test_flap_to_ground();
        int ey [19] = '{60, 56, 53, 51, 50, 50, 51, 53, 56, 60, 65, 71, 77, 83, 89, 95, 101, 107, 112};
        int ev [19] = '{-4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 6, 6, 6, 6, 6, 6, 6, 6};
        int es [19] = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3};
        press_key = 1'b1;
        @(negedge clk);
        press_key = 1'b0;
        for (int k = 0; k < 19; k++) begin
            frame_end();
            checks++;
            if (state !== 4'(es[k]) || bird_y !== 7'(ey[k]) || vy !== 5'(ev[k])) begin
                errors++;
                $display("FAIL flap_frame%0d got st=%0d y=%0d vy=%0d exp st=%0d y=%0d vy=%0d",
                         k, state, bird_y, vy, es[k], ey[k], ev[k]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (state !== 4'd3 || game_over !== 1'b1 || bird_y !== 7'd112 || vy !== 5'sd6) begin
            errors++;
            $display("FAIL ground_frozen got st=%0d go=%b y=%0d vy=%0d exp st=3 go=1 y=112 vy=6",
                     state, game_over, bird_y, vy);
        end
        press_key = 1'b1;
        @(negedge clk);
        press_key = 1'b0;
        checks++;
        if (state !== 4'd0 || bird_y !== 7'd60 || vy !== 5'sd0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL restart got st=%0d y=%0d vy=%0d go=%b exp st=0 y=60 vy=0 go=0",
                     state, bird_y, vy, game_over);
        end
    endtask

    task automatic test_collision();
        press_key = 1'b1;
        @(negedge clk);
        press_key = 1'b0;
        repeat (5) frame_end();
        checks++;
        if (state !== 4'd2 || bird_y !== 7'd50 || vy !== 5'sd0) begin
            errors++;
            $display("FAIL coll_pre got st=%0d y=%0d vy=%0d exp st=2 y=50 vy=0", state, bird_y, vy);
        end
        @(negedge clk);
        repeat (10) @(negedge clk);
        touched   = 1'b1;
        press_key = 1'b1;
        @(negedge clk);
        touched   = 1'b0;
        press_key = 1'b0;
        frame_end();
        checks++;
        if (state !== 4'd3 || game_over !== 1'b1 || bird_y !== 7'd50) begin
            errors++;
            $display("FAIL coll_stop got st=%0d go=%b y=%0d exp st=3 go=1 y=50", state, game_over, bird_y);
        end
        press_key = 1'b1;
        @(negedge clk);
        press_key = 1'b0;
        checks++;
        if (state !== 4'd0 || bird_y !== 7'd60) begin
            errors++;
            $display("FAIL coll_restart got st=%0d y=%0d exp st=0 y=60", state, bird_y);
        end
    endtask

    task automatic test_ceiling();
        int n;
        rst_c   = 1'b0;
        press_c = 1'b1;
        @(negedge clk);
        press_c = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (state_c !== 4'd7 && n < 400) begin
                @(negedge clk);
                n++;
            end
            if (k == 0) @(negedge clk);
        end
        checks++;
        if (bird_y_c !== 7'd0 || vy_c !== 5'sd0 || state_c !== 4'd7) begin
            errors++;
            $display("FAIL ceil_clamp got st=%0d y=%0d vy=%0d exp st=7 y=0 vy=0", state_c, bird_y_c, vy_c);
        end
        @(negedge clk);
        checks++;
        if (state_c !== 4'd2 || bird_y_c !== 7'd0 || vy_c !== 5'sd1) begin
            errors++;
            $display("FAIL ceil_next got st=%0d y=%0d vy=%0d exp st=2 y=0 vy=1", state_c, bird_y_c, vy_c);
        end
    endtask

    task automatic test_held_key();
`ifdef BIRD_FLAP_EDGE_EN
        int ey [5] = '{60, 56, 53, 51, 50};
        int ev [5] = '{-4, -3, -2, -1, 0};
        int es [5] = '{1, 1, 1, 1, 2};
`else
        int ey [5] = '{60, 56, 52, 48, 44};
        int ev [5] = '{-4, -4, -4, -4, -4};
        int es [5] = '{1, 1, 1, 1, 1};
`endif
        wait_main_state(4'd0);
        press_key = 1'b1;
        for (int k = 0; k < 5; k++) begin
            frame_end();
            checks++;
            if (state !== 4'(es[k]) || bird_y !== 7'(ey[k]) || vy !== 5'(ev[k])) begin
                errors++;
                $display("FAIL held_frame%0d got st=%0d y=%0d vy=%0d exp st=%0d y=%0d vy=%0d",
                         k, state, bird_y, vy, es[k], ey[k], ev[k]);
            end
        end
        press_key = 1'b0;
    endtask

    task automatic test_async_reset();
        wait_main_state(4'd4);
        repeat (5) @(negedge clk);
        checks++;
        if (draw_en !== 1'b1 || bird_y === 7'd60) begin
            errors++;
            $display("FAIL areset_pre got de=%b y=%0d exp de=1 y!=60", draw_en, bird_y);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || bird_y !== 7'd60 || vy !== 5'sd0 ||
            {draw_en, erase_en, game_over} !== 3'b000) begin
            errors++;
            $display("FAIL areset got st=%0d y=%0d vy=%0d str=%b exp st=0 y=60 vy=0 str=000",
                     state, bird_y, vy, {draw_en, erase_en, game_over});
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 4'd4 || bird_y !== 7'd60) begin
            errors++;
            $display("FAIL areset_resume got st=%0d y=%0d exp st=4 y=60", state, bird_y);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_flap_to_ground();
        test_collision();
        test_ceiling();
        test_held_key();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
